// File: rtl/multi_line_buffer.sv
// Multi-tap line buffer: keeps the last NUM_TAPS-1 image lines and emits one
// vertical pixel column per accepted input pixel through a single registered output stage.
module multi_line_buffer #(
   parameter int BIT_WIDTH      = 8,
   parameter int MAX_LINE_WIDTH = 640,
   parameter int NUM_TAPS       = 8
) (
   input  logic                                 clk,
   input  logic                                 n_rst,
   input  logic [$clog2(MAX_LINE_WIDTH+1)-1:0]  i_line_width,
   input  logic                                 i_valid,
   input  logic                                 i_sof,
   input  logic [BIT_WIDTH-1:0]                 i_data,
   output logic                                 o_ready,
   output logic                                 o_valid,
   input  logic                                 i_ready,
   output logic [NUM_TAPS*BIT_WIDTH-1:0]        o_data,
   output logic [NUM_TAPS-1:0]                  o_tap_valid,
   output logic                                 o_sol,
   output logic                                 o_eol
);
   localparam int LW_W  = $clog2(MAX_LINE_WIDTH+1);
   localparam int COL_W = (MAX_LINE_WIDTH > 1) ? $clog2(MAX_LINE_WIDTH) : 1;
   localparam int ROW_W = $clog2(NUM_TAPS);
   localparam int MEM_W = (NUM_TAPS-1)*BIT_WIDTH;
   localparam int OUT_W = NUM_TAPS*BIT_WIDTH;
   localparam logic [LW_W-1:0]  MAX_W    = LW_W'(MAX_LINE_WIDTH);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_TAPS-1);

   // Word at column c holds stored rows 0..NUM_TAPS-2 for that column, row 0 in the low bits.
   logic [MEM_W-1:0]    r_mem [MAX_LINE_WIDTH];

   logic [COL_W-1:0]    r_col;
   logic [ROW_W-1:0]    r_row;
   logic [LW_W-1:0]     r_width;
   logic                r_valid;
   logic [OUT_W-1:0]    r_data;
   logic [NUM_TAPS-1:0] r_tap_valid;
   logic                r_sol;
   logic                r_eol;

   logic                w_ready;
   logic                w_accept;
   logic                w_sof;
   logic [COL_W-1:0]    w_col;
   logic [ROW_W-1:0]    w_row;
   logic [LW_W-1:0]     w_width;
   logic [LW_W-1:0]     w_last;
   logic [MEM_W-1:0]    w_rd;
   logic [MEM_W-1:0]    w_wr;
   logic [OUT_W-1:0]    w_data;
   logic [NUM_TAPS-1:0] w_tap_valid;
   logic                w_sol;
   logic                w_eol;
   logic [COL_W-1:0]    w_col_nxt;
   logic [ROW_W-1:0]    w_row_nxt;

   assign w_ready  = n_rst & (~r_valid | i_ready);
   assign w_accept = i_valid & w_ready;
   assign w_rd     = r_mem[w_col];

   // Effective position, line width, output column and shifted write-back for this pixel.
   always_comb begin
      w_sof = i_valid & i_sof;
      if (w_sof) begin
         w_col = {COL_W{1'b0}};
         w_row = {ROW_W{1'b0}};
      end else begin
         w_col = r_col;
         w_row = r_row;
      end

      if (w_col != {COL_W{1'b0}}) begin
         w_width = r_width;
      end else if ((i_line_width == {LW_W{1'b0}}) || (i_line_width > MAX_W)) begin
         w_width = MAX_W;
      end else begin
         w_width = i_line_width;
      end
      w_last = w_width - LW_W'(1);

      w_data      = {OUT_W{1'b0}};
      w_tap_valid = {NUM_TAPS{1'b0}};
      w_wr        = {MEM_W{1'b0}};
      w_data[BIT_WIDTH-1:0] = i_data;
      w_tap_valid[0]        = 1'b1;
      w_wr[BIT_WIDTH-1:0]   = i_data;
      // Taps above the rows seen so far in this frame are forced to zero.
      for (int k = 1; k < NUM_TAPS; k++) begin
         if (w_row >= ROW_W'(k)) begin
            w_tap_valid[k]                   = 1'b1;
            w_data[k*BIT_WIDTH +: BIT_WIDTH] = w_rd[(k-1)*BIT_WIDTH +: BIT_WIDTH];
         end else begin
            w_tap_valid[k]                   = 1'b0;
            w_data[k*BIT_WIDTH +: BIT_WIDTH] = {BIT_WIDTH{1'b0}};
         end
      end
      for (int k = 1; k < NUM_TAPS-1; k++) begin
         w_wr[k*BIT_WIDTH +: BIT_WIDTH] = w_rd[(k-1)*BIT_WIDTH +: BIT_WIDTH];
      end

      w_sol = (w_col == {COL_W{1'b0}});
      w_eol = (LW_W'(w_col) == w_last);
      if (w_eol) begin
         w_col_nxt = {COL_W{1'b0}};
         if (w_row == LAST_ROW) begin
            w_row_nxt = w_row;
         end else begin
            w_row_nxt = w_row + ROW_W'(1);
         end
      end else begin
         w_col_nxt = w_col + COL_W'(1);
         w_row_nxt = w_row;
      end
   end

   // Position counters and the registered output stage.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_col       <= {COL_W{1'b0}};
         r_row       <= {ROW_W{1'b0}};
         r_width     <= MAX_W;
         r_valid     <= 1'b0;
         r_data      <= {OUT_W{1'b0}};
         r_tap_valid <= {NUM_TAPS{1'b0}};
         r_sol       <= 1'b0;
         r_eol       <= 1'b0;
      end else if (w_accept) begin
         r_col       <= w_col_nxt;
         r_row       <= w_row_nxt;
         r_width     <= w_width;
         r_valid     <= 1'b1;
         r_data      <= w_data;
         r_tap_valid <= w_tap_valid;
         r_sol       <= w_sol;
         r_eol       <= w_eol;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   // Line storage is deliberately left unreset; masking hides stale contents.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[w_col] <= w_wr;
      end
   end

   assign o_ready     = w_ready;
   assign o_valid     = r_valid;
   assign o_data      = r_data;
   assign o_tap_valid = r_tap_valid;
   assign o_sol       = r_sol;
   assign o_eol       = r_eol;
endmodule
